// File: rtl/alu_share_arb_if.sv
// Bundle between the two client engines, the shared ALU and alu_share_arb.
// The master side is the clients plus the ALU; the slave side is the arbiter.
interface alu_share_arb_if #(
  parameter int WIDTH = 32
);
  // valid/ready: a beat transfers on a rising clk edge where both are high;
  // the source holds its payload stable while valid is high and ready is low.
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]       req0_s, req1_s;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp0_out, rsp1_out;
  logic             rsp0_cout, rsp1_cout;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [1:0]       alu_s;
  logic [WIDTH-1:0] alu_out;
  logic             alu_cout;
  logic             busy;

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_s, req1_s, rsp0_ready, rsp1_ready, alu_out, alu_cout,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_out,
           rsp1_out, rsp0_cout, rsp1_cout, alu_a, alu_b, alu_s, busy
  );

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_s, req1_s, rsp0_ready, rsp1_ready, alu_out, alu_cout,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_out,
           rsp1_out, rsp0_cout, rsp1_cout, alu_a, alu_b, alu_s, busy
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter that serialises two requesters onto one combinational
// ALU: accept in IDLE, capture the result in EXEC, hand it back in RESP.
module alu_share_arb #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  alu_share_arb_if.slave  bus,
  output logic [1:0]      o_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       r_state;
  logic             r_ptr;
  logic             r_owner;
  logic [WIDTH-1:0] r_alu_a, r_alu_b;
  logic [1:0]       r_alu_s;
  logic [WIDTH-1:0] r_res;
  logic             r_cout;

  logic w_idle, w_gnt0, w_gnt1, w_acc0, w_acc1, w_rsp_take;

  always_comb begin
    w_idle     = (r_state == IDLE);
    // ptr names the requester with priority; the other wins only if ptr is idle
    w_gnt0     = bus.req0_valid && (!r_ptr || !bus.req1_valid);
    w_gnt1     = bus.req1_valid && ( r_ptr || !bus.req0_valid);
    w_acc0     = w_idle && w_gnt0 && !rst;
    w_acc1     = w_idle && w_gnt1 && !rst;
    w_rsp_take = r_owner ? bus.rsp1_ready : bus.rsp0_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_alu_a <= '0;
      r_alu_b <= '0;
      r_alu_s <= 2'd0;
      r_res   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc0) begin
            r_alu_a <= bus.req0_a;
            r_alu_b <= bus.req0_b;
            r_alu_s <= bus.req0_s;
            r_owner <= 1'b0;
            r_state <= EXEC;
          end else if (w_acc1) begin
            r_alu_a <= bus.req1_a;
            r_alu_b <= bus.req1_b;
            r_alu_s <= bus.req1_s;
            r_owner <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_res   <= bus.alu_out;
          r_cout  <= bus.alu_cout;
          r_state <= RESP;
        end
        RESP: begin
          if (w_rsp_take) begin
            r_ptr   <= ~r_owner;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = w_acc0;
  assign bus.req1_ready = w_acc1;
  assign bus.rsp0_valid = (r_state == RESP) && !r_owner;
  assign bus.rsp1_valid = (r_state == RESP) &&  r_owner;
  assign bus.rsp0_out   = r_res;
  assign bus.rsp1_out   = r_res;
  assign bus.rsp0_cout  = r_cout;
  assign bus.rsp1_cout  = r_cout;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_s      = r_alu_s;
  assign bus.busy       = (r_state != IDLE);
  assign o_state        = r_state;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU (0 add, 1 sub,
// 2 and, 3 or); expected results are hand-computed constants.
module tb_alu_share_arb;
  logic       clk;
  logic       rst;
  logic [1:0] state;
  int         n_chk;
  int         n_fail;

  alu_share_arb_if #(.WIDTH(32)) bus ();

  alu_share_arb #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.alu_cout = 1'b0;
    bus.alu_out  = '0;
    case (bus.alu_s)
      2'd0: {bus.alu_cout, bus.alu_out} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      2'd1: bus.alu_out = bus.alu_a - bus.alu_b;
      2'd2: bus.alu_out = bus.alu_a & bus.alu_b;
      default: bus.alu_out = bus.alu_a | bus.alu_b;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int port, input logic [31:0] a,
                           input logic [31:0] b, input logic [1:0] s);
    if (port == 0) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_s = s;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_s = s;
    end
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_s = 2'd0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_s = 2'd0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    n_chk++; if ({bus.alu_a, bus.alu_b, bus.alu_s} !== 66'd0) begin n_fail++; $display("FAIL reset_alu_regs: got %h/%h/%0d want 0", bus.alu_a, bus.alu_b, bus.alu_s); end
    n_chk++; if ({bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready} !== 4'b0) begin n_fail++; $display("FAIL reset_handshake: got %b want 0000", {bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready}); end
    n_chk++; if ({bus.rsp0_out, bus.rsp0_cout} !== 33'd0) begin n_fail++; $display("FAIL reset_result: got %h/%0b want 0", bus.rsp0_out, bus.rsp0_cout); end
  endtask

  task automatic test_single();
    drive_req(0, 32'd14, 32'd23, 2'd0);
    bus.rsp0_ready = 1'b1;
    #1;
    n_chk++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
    tick();
    bus.req0_valid = 1'b0;
    #1;
    n_chk++; if (bus.alu_a !== 32'd14 || bus.alu_b !== 32'd23) begin n_fail++; $display("FAIL single_exec_ops: got %0d/%0d want 14/23", bus.alu_a, bus.alu_b); end
    n_chk++; if (bus.busy !== 1'b1 || bus.rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL single_exec_flags: busy %0b rsp0_valid %0b want 1/0", bus.busy, bus.rsp0_valid); end
    tick();
    n_chk++; if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_valid: got %0b%0b want 10", bus.rsp0_valid, bus.rsp1_valid); end
    n_chk++; if (bus.rsp0_out !== 32'd37 || bus.rsp0_cout !== 1'b0) begin n_fail++; $display("FAIL single_rsp_data: got %0d/%0b want 37/0", bus.rsp0_out, bus.rsp0_cout); end
    tick();
    n_chk++; if (state !== 2'd0 || bus.rsp0_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_done: state %0d rsp0_valid %0b busy %0b want 0/0/0", state, bus.rsp0_valid, bus.busy); end
  endtask

  task automatic test_alternation();
    idle_inputs();
    rst = 1'b1;
    drive_req(0, 32'd74, 32'd200, 2'd0);
    drive_req(1, 32'd140, 32'd213, 2'd1);
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_chk++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL alt_first_grant: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
    tick();
    drive_req(0, 32'd5, 32'd6, 2'd0);
    #1;
    n_chk++; if (bus.alu_a !== 32'd74 || bus.alu_b !== 32'd200) begin n_fail++; $display("FAIL alt_exec0: got %0d/%0d want 74/200", bus.alu_a, bus.alu_b); end
    tick();
    n_chk++; if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0 || bus.rsp0_out !== 32'd274) begin n_fail++; $display("FAIL alt_rsp0: valid %0b%0b out %0d want 10/274", bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_out); end
    tick();
    n_chk++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin n_fail++; $display("FAIL alt_second_grant: got %b want 01", {bus.req0_ready, bus.req1_ready}); end
    tick();
    bus.req1_valid = 1'b0;
    #1;
    n_chk++; if (bus.alu_a !== 32'd140 || bus.alu_s !== 2'd1) begin n_fail++; $display("FAIL alt_exec1: got %0d/s%0d want 140/s1", bus.alu_a, bus.alu_s); end
    tick();
    n_chk++; if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp1_out !== 32'hFFFF_FFB7) begin n_fail++; $display("FAIL alt_rsp1: valid %0b%0b out %h want 01/ffffffb7", bus.rsp0_valid, bus.rsp1_valid, bus.rsp1_out); end
    tick();
    n_chk++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL alt_third_grant: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
    tick();
    bus.req0_valid = 1'b0;
    tick();
    n_chk++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_out !== 32'd11) begin n_fail++; $display("FAIL alt_rsp0_again: valid %0b out %0d want 1/11", bus.rsp0_valid, bus.rsp0_out); end
    tick();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    drive_req(1, 32'd1000, 32'd24, 2'd0);
    #1;
    n_chk++; if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_grant1: got %0b want 1", bus.req1_ready); end
    tick();
    bus.req1_valid = 1'b0;
    drive_req(0, 32'd3, 32'd4, 2'd0);
    bus.rsp0_ready = 1'b1;
    #1;
    n_chk++; if (bus.req0_ready !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL bp_exec: req0_ready %0b busy %0b want 0/1", bus.req0_ready, bus.busy); end
    tick();
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (bus.rsp1_valid !== 1'b1 || bus.rsp1_out !== 32'd1024 || bus.busy !== 1'b1 || bus.req0_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall%0d: rsp1_valid %0b out %0d busy %0b req0_ready %0b want 1/1024/1/0", i, bus.rsp1_valid, bus.rsp1_out, bus.busy, bus.req0_ready);
      end
      tick();
    end
    bus.rsp1_ready = 1'b1;
    tick();
    n_chk++; if (state !== 2'd0 || bus.busy !== 1'b0 || bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: state %0d busy %0b req0_ready %0b want 0/0/1", state, bus.busy, bus.req0_ready); end
    tick();
    bus.req0_valid = 1'b0;
    tick();
    n_chk++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_out !== 32'd7) begin n_fail++; $display("FAIL bp_followup: valid %0b out %0d want 1/7", bus.rsp0_valid, bus.rsp0_out); end
    tick();
  endtask

  task automatic test_carry();
    idle_inputs();
    bus.rsp1_ready = 1'b1;
    drive_req(1, 32'hFFFF_FFFF, 32'd1, 2'd0);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    n_chk++; if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL carry_valid: got %0b%0b want 01", bus.rsp0_valid, bus.rsp1_valid); end
    n_chk++; if (bus.rsp1_out !== 32'd0 || bus.rsp1_cout !== 1'b1) begin n_fail++; $display("FAIL carry_data: got %h/%0b want 0/1", bus.rsp1_out, bus.rsp1_cout); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    idle_inputs();
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    drive_req(0, 32'd2, 32'd3, 2'd0);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    tick();
    drive_req(1, 32'd9, 32'd9, 2'd0);
    tick();
    bus.req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_chk++; if (state !== 2'd0 || bus.busy !== 1'b0 || bus.alu_a !== 32'd0) begin n_fail++; $display("FAIL rst_mid_async: state %0d busy %0b alu_a %0d want 0/0/0", state, bus.busy, bus.alu_a); end
    n_chk++; if (bus.rsp0_out !== 32'd0 || bus.rsp1_valid !== 1'b0 || bus.rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rsp: out %0d valid %0b%0b want 0/00", bus.rsp0_out, bus.rsp0_valid, bus.rsp1_valid); end
    drive_req(0, 32'd1, 32'd1, 2'd0);
    drive_req(1, 32'd2, 32'd2, 2'd0);
    tick();
    n_chk++; if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid} !== 4'b0) begin n_fail++; $display("FAIL rst_mid_hold: got %b want 0000", {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid}); end
    rst = 1'b0;
    #1;
    n_chk++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL rst_mid_regrant: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tick();
    n_chk++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_out !== 32'd2) begin n_fail++; $display("FAIL rst_mid_after: valid %0b out %0d want 1/2", bus.rsp0_valid, bus.rsp0_out); end
    tick();
  endtask

  task automatic test_operand_isolation();
    idle_inputs();
    bus.rsp0_ready = 1'b1;
    drive_req(0, 32'd1023, 32'd123, 2'd2);
    tick();
    bus.req0_valid = 1'b0;
    bus.req0_a = 32'd5;
    #1;
    n_chk++; if (bus.alu_a !== 32'd1023 || bus.alu_s !== 2'd2) begin n_fail++; $display("FAIL iso_exec: got %0d/s%0d want 1023/s2", bus.alu_a, bus.alu_s); end
    tick();
    n_chk++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_out !== 32'd123) begin n_fail++; $display("FAIL iso_result: valid %0b out %0d want 1/123", bus.rsp0_valid, bus.rsp0_out); end
    tick();
    n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL iso_idle: got %0d want 0", state); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_alternation();
    test_backpressure();
    test_carry();
    test_reset_mid_op();
    test_operand_isolation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1, "timeout");
  end
endmodule
